// File: rtl/matrix_fifo_sync_prefetch_pkg.sv
// Shared constants and helpers for the prefetch FIFO.
// Optional error flags are enabled with the MATRIX_FIFO_ERR_EN macro.
package matrix_fifo_sync_prefetch_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH_W   = 10;
    // Pointer width equals the depth exponent; pointers wrap naturally at CAP.
    localparam int unsigned DEF_PTR_W     = DEF_DEPTH_W;
    localparam int unsigned DEF_AF_MARGIN = 4;
    localparam int unsigned DEF_AE_LEVEL  = 4;

    function automatic int unsigned fifo_cap(input int unsigned depth_w);
        return 32'd1 << depth_w;
    endfunction

    // Bits needed to hold values 0..v-1.
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_fifo_sync_prefetch_if.sv
// Handshake bundle between the pixel stream, the FIFO and the window builder.
// MATRIX_FIFO_ERR_EN adds the sticky ovf_err/udf_err outputs.
interface matrix_fifo_sync_prefetch_if #(
    parameter int unsigned DATA_W  = matrix_fifo_sync_prefetch_pkg::DEF_DATA_W,
    parameter int unsigned DEPTH_W = matrix_fifo_sync_prefetch_pkg::DEF_PTR_W
);

    logic              flush;
    logic              wr_en;
    logic              wr_vld;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic [DEPTH_W:0]  cnt;
    logic              almost_full;
    logic              almost_empty;
`ifdef MATRIX_FIFO_ERR_EN
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  wr_vld, rd_vld, rd_data, cnt, almost_full, almost_empty, ovf_err, udf_err
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output wr_vld, rd_vld, rd_data, cnt, almost_full, almost_empty, ovf_err, udf_err
    );
`else
    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  wr_vld, rd_vld, rd_data, cnt, almost_full, almost_empty
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output wr_vld, rd_vld, rd_data, cnt, almost_full, almost_empty
    );
`endif

endinterface

// File: rtl/matrix_fifo_sync_prefetch_sdpram.sv
// Simple dual-port RAM, one write port, one registered read port with read enable.
// The read register is the FIFO output stage: it resets to zero and holds when not enabled.
module matrix_fifo_sync_prefetch_sdpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Array write port.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read; output holds its value unless a read is issued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_fifo_sync_prefetch.sv
// Single-clock first-word-fall-through FIFO for the matrix/line-buffer path.
// MATRIX_FIFO_ERR_EN enables sticky overflow/underflow error outputs.
module matrix_fifo_sync_prefetch
    import matrix_fifo_sync_prefetch_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH_W  = DEF_DEPTH_W,
    parameter int unsigned AF_LEVEL = fifo_cap(DEF_DEPTH_W) - DEF_AF_MARGIN,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    matrix_fifo_sync_prefetch_if.slave io_fifo
);

    localparam int unsigned CAP   = fifo_cap(DEPTH_W);
    localparam int unsigned CNT_W = clog2_u(CAP + 1);

    logic [DEPTH_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rd_vld, r_wr_vld, r_af, r_ae;
    logic [CNT_W-1:0]   w_cnt_nxt, w_unread;
    logic               w_clr, w_push, w_pop, w_ram_rd;
    logic [DATA_W-1:0]  w_rd_data;

    // Reset and flush clear the same state and suppress any transfer that cycle.
    assign w_clr    = !i_rst_n || io_fifo.flush;
    assign w_push   = io_fifo.wr_en && r_wr_vld && !w_clr;
    assign w_pop    = io_fifo.rd_en && r_rd_vld && !w_clr;
    // Words still in the RAM; the prefetched head is counted in cnt but already read out.
    assign w_unread = r_cnt - CNT_W'(r_rd_vld);
    assign w_ram_rd = (w_unread != '0) && (!r_rd_vld || w_pop) && !w_clr;
    assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

    // Pointers, fill count, prefetch valid and registered flags.
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_rd_vld <= 1'b0;
            r_wr_vld <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
            if (w_ram_rd) r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
            if (w_ram_rd)   r_rd_vld <= 1'b1;
            else if (w_pop) r_rd_vld <= 1'b0;
            r_cnt    <= w_cnt_nxt;
            r_wr_vld <= w_cnt_nxt != CNT_W'(CAP);
            r_af     <= w_cnt_nxt >= CNT_W'(AF_LEVEL);
            r_ae     <= w_cnt_nxt <= CNT_W'(AE_LEVEL);
        end
    end

    matrix_fifo_sync_prefetch_sdpram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_fifo.wr_data),
        .i_re    (w_ram_rd),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign io_fifo.wr_vld       = r_wr_vld;
    assign io_fifo.rd_vld       = r_rd_vld;
    assign io_fifo.rd_data      = w_rd_data;
    assign io_fifo.cnt          = r_cnt;
    assign io_fifo.almost_full  = r_af;
    assign io_fifo.almost_empty = r_ae;

`ifdef MATRIX_FIFO_ERR_EN
    logic r_ovf_err, r_udf_err;

    // Sticky flags for requests made against a full or empty FIFO.
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (io_fifo.wr_en && !r_wr_vld) r_ovf_err <= 1'b1;
            if (io_fifo.rd_en && !r_rd_vld) r_udf_err <= 1'b1;
        end
    end

    assign io_fifo.ovf_err = r_ovf_err;
    assign io_fifo.udf_err = r_udf_err;
`endif

endmodule

// File: tb/tb_matrix_fifo_sync_prefetch.sv
// Scoreboard bench for matrix_fifo_sync_prefetch (8b x 1024, AF 1020, AE 4).
// Build with MATRIX_FIFO_ERR_EN defined to also check the sticky error flags.
module tb_matrix_fifo_sync_prefetch;

    localparam int unsigned DW  = 8;
    localparam int unsigned DPW = 10;
    localparam int unsigned CAP = 1024;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [DW-1:0] q_exp [$];

    matrix_fifo_sync_prefetch_if #(.DATA_W(DW), .DEPTH_W(DPW)) u_if ();

    matrix_fifo_sync_prefetch #(
        .DATA_W   (DW),
        .DEPTH_W  (DPW),
        .AF_LEVEL (1020),
        .AE_LEVEL (4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_fifo (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: inputs are stable at the falling edge, so decide here what the next
    // rising edge will do.
    always @(negedge clk) begin
        if (!rst_n || u_if.flush) begin
            q_exp.delete();
        end else begin
            if (u_if.rd_en && u_if.rd_vld) begin
                if (q_exp.size() == 0) chk("sb_underflow_rd_vld", u_if.rd_vld, 1'b0);
                else                   chk("rd_data", u_if.rd_data, q_exp.pop_front());
            end
            if (u_if.wr_en && u_if.wr_vld) q_exp.push_back(u_if.wr_data);
        end
    end

    // Advance one cycle and check count/flags against the scoreboard occupancy.
    task automatic step();
        int sz;
        @(posedge clk);
        #1;
        sz = q_exp.size();
        chk("cnt", u_if.cnt, sz);
        chk("wr_vld", u_if.wr_vld, sz != CAP);
        chk("almost_full", u_if.almost_full, sz >= 1020);
        chk("almost_empty", u_if.almost_empty, sz <= 4);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_vld"}, u_if.rd_vld, 1'b0);
        chk({tag, "_wr_vld"}, u_if.wr_vld, 1'b1);
        chk({tag, "_rd_data"}, u_if.rd_data, 0);
        chk({tag, "_af"}, u_if.almost_full, 1'b0);
        chk({tag, "_ae"}, u_if.almost_empty, 1'b1);
        chk({tag, "_cnt"}, u_if.cnt, 0);
`ifdef MATRIX_FIFO_ERR_EN
        chk({tag, "_ovf"}, u_if.ovf_err, 1'b0);
        chk({tag, "_udf"}, u_if.udf_err, 1'b0);
`endif
    endtask

    task automatic drain(input string tag);
        u_if.wr_en = 1'b0;
        u_if.rd_en = 1'b1;
        for (int i = 0; i < CAP + 16 && q_exp.size() != 0; i++) step();
        u_if.rd_en = 1'b0;
        chk({tag, "_drained"}, q_exp.size(), 0);
        step();
        chk({tag, "_rd_vld_after"}, u_if.rd_vld, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] saved;
        int gaps;
        int cnt_var;
        int cnt_ref;
        bit seen;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.flush   = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.rd_en   = 1'b0;
        u_if.wr_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Single write: visible two cycles later
        u_if.wr_en = 1'b1;
        u_if.wr_data = 8'hA5;
        step();
        u_if.wr_en = 1'b0;
        chk("lat1_rd_vld", u_if.rd_vld, 1'b0);
        step();
        chk("lat2_rd_vld", u_if.rd_vld, 1'b1);
        chk("lat2_rd_data", u_if.rd_data, 8'hA5);
        chk("lat2_cnt", u_if.cnt, 1);
        u_if.rd_en = 1'b1;
        step();
        chk("pop_rd_vld", u_if.rd_vld, 1'b0);
        chk("pop_hold_data", u_if.rd_data, 8'hA5);
        // Read on empty is ignored
        step();
        u_if.rd_en = 1'b0;
        chk("empty_rd_hold_data", u_if.rd_data, 8'hA5);
        chk("empty_rd_cnt", u_if.cnt, 0);
`ifdef MATRIX_FIFO_ERR_EN
        chk("udf_err_set", u_if.udf_err, 1'b1);
`endif

        // Fill to capacity
        for (int i = 0; i < CAP; i++) begin
            u_if.wr_en = 1'b1;
            u_if.wr_data = DW'(i);
            step();
        end
        chk("full_cnt", u_if.cnt, CAP);
        chk("full_wr_vld", u_if.wr_vld, 1'b0);
        chk("full_af", u_if.almost_full, 1'b1);
        u_if.wr_data = 8'hEE;
        step();
        chk("ovf_write_dropped_cnt", u_if.cnt, CAP);
`ifdef MATRIX_FIFO_ERR_EN
        chk("ovf_err_set", u_if.ovf_err, 1'b1);
`endif
        // Full: simultaneous write and pop, only the pop happens
        u_if.rd_en = 1'b1;
        step();
        chk("full_wrrd_cnt", u_if.cnt, CAP - 1);
        chk("full_wrrd_wr_vld", u_if.wr_vld, 1'b1);
        drain("fill");

        // Continuous write+pop streaming through pointer wrap
        gaps = 0;
        cnt_var = 0;
        cnt_ref = 0;
        seen = 1'b0;
        u_if.rd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            u_if.wr_en = 1'b1;
            u_if.wr_data = DW'($urandom);
            step();
            if (seen && !u_if.rd_vld) gaps++;
            if (u_if.rd_vld) seen = 1'b1;
            if (i == 4) cnt_ref = int'(u_if.cnt);
            if (i > 4 && int'(u_if.cnt) != cnt_ref) cnt_var++;
        end
        chk("stream_gaps", gaps, 0);
        chk("stream_cnt_changes", cnt_var, 0);
        chk("stream_cnt_level", cnt_ref, 2);
        drain("stream");

        // Flush with 10 words held and a concurrent write
        for (int i = 0; i < 10; i++) begin
            u_if.wr_en = 1'b1;
            u_if.wr_data = DW'(8'h30 + i);
            step();
        end
        u_if.wr_en = 1'b0;
        step();
        chk("preflush_cnt", u_if.cnt, 10);
        saved = u_if.rd_data;
        u_if.flush = 1'b1;
        u_if.wr_en = 1'b1;
        u_if.wr_data = 8'h77;
        step();
        u_if.flush = 1'b0;
        u_if.wr_en = 1'b0;
        chk("flush_cnt", u_if.cnt, 0);
        chk("flush_rd_vld", u_if.rd_vld, 1'b0);
        chk("flush_ae", u_if.almost_empty, 1'b1);
        chk("flush_rd_data_hold", u_if.rd_data, saved);
`ifdef MATRIX_FIFO_ERR_EN
        chk("flush_ovf_clr", u_if.ovf_err, 1'b0);
        chk("flush_udf_clr", u_if.udf_err, 1'b0);
`endif
        step();
        chk("flush_write_discarded", u_if.cnt, 0);

        // Reset mid-burst at cnt=37
        for (int i = 0; i < 37; i++) begin
            u_if.wr_en = 1'b1;
            u_if.wr_data = DW'(8'h80 + i);
            step();
        end
        chk("burst_cnt", u_if.cnt, 37);
        rst_n = 1'b0;
        u_if.rd_en = 1'b1;
        step();
        rst_n = 1'b1;
        u_if.wr_en = 1'b0;
        u_if.rd_en = 1'b0;
        chk_reset_vals("midrst");
        u_if.rd_en = 1'b1;
        step();
        u_if.rd_en = 1'b0;
        chk("midrst_empty_rd_cnt", u_if.cnt, 0);
        chk("midrst_empty_rd_vld", u_if.rd_vld, 1'b0);
`ifdef MATRIX_FIFO_ERR_EN
        chk("midrst_udf_set", u_if.udf_err, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
